trace_buffer: RTL and testbench
===============================

// Module: trace_buffer
// PURPOSE
// - Circular on-chip trace store directly downstream of the data packer: captures packed N-wide vectors while tracing.
// - When tracing stops, drains the stored vectors oldest-first over a valid/ready read port to the host-side readout logic.
// - Oldest entries are overwritten once full, so the buffer always holds the most recent TB_SIZE vectors.
// PARAMETERS
// N           8   lanes per vector; must match packer N
// DATA_WIDTH  32  bits per lane
// TB_SIZE     64  buffer depth in vectors; power of 2, >=2
// PORTS
// clk         in   1                  rising-edge clock
// reset       in   1                  async, active-high
// tracing     in   1                  capture enable
// valid_in    in   1                  packed vector present (packer valid_out)
// vector_in   in   DATA_WIDTH x N     packed vector (packer vector_out)
// drain       in   1                  single-cycle request to start readout
// rd_ready    in   1                  consumer accepts vector_out this cycle
// rd_valid    out  1                  vector_out holds a valid entry
// vector_out  out  DATA_WIDTH x N     entry being read out
// rd_last     out  1                  current entry is the newest stored vector
// count       out  $clog2(TB_SIZE+1)  entries currently stored, 0..TB_SIZE
// wrapped     out  1                  sticky: >=1 entry overwritten since last empty
// busy        out  1                  high in FETCH or SEND
// BEHAVIOUR
// - Reset: FSM=IDLE; wr_ptr=rd_ptr=0; count=0; wrapped=0; rd_valid=0; rd_last=0; busy=0; vector_out all 0. Memory array is not reset.
// - Write: in IDLE, valid_in&tracing writes vector_in at wr_ptr; wr_ptr+1 mod TB_SIZE.
//   - count<TB_SIZE: count+1.
//   - count==TB_SIZE: rd_ptr+1 mod TB_SIZE (oldest dropped); wrapped<=1; count unchanged.
//   - Writes in FETCH/SEND are dropped silently; pointers and count unchanged.
// - FSM IDLE -> FETCH: drain & !tracing & count>0. busy<=1.
//   - drain with tracing=1, or with count==0: ignored, stays IDLE.
//   - Simultaneous valid_in&tracing&drain: write happens, drain ignored.
// - FETCH (1 cycle): synchronous memory read at rd_ptr -> SEND.
// - SEND: rd_valid=1; vector_out=mem[rd_ptr]; rd_last=(count==1).
//   - vector_out/rd_last stable while rd_valid & !rd_ready.
//   - On rd_valid&rd_ready: rd_ptr+1 mod TB_SIZE; count-1; rd_valid<=0.
//     - count was 1: -> IDLE; busy<=0; wrapped<=0; wr_ptr=rd_ptr.
//     - else: -> FETCH.
// - Latency: drain to first rd_valid = 2 cycles. Peak throughput 1 vector per 2 cycles.
// - drain while busy: ignored.
// - tracing rising mid-readout: no effect until IDLE.
// - Reset mid-readout: immediate return to reset state; remaining entries lost.
// - Pointer arithmetic is $clog2(TB_SIZE) bits with natural wrap. count never exceeds TB_SIZE or goes below 0.
// TESTING (TB_SIZE=4, N=8, DATA_WIDTH=32)
// 1. tracing=1, write 3 vectors (lane0=1,2,3), tracing=0, drain, rd_ready=1
//    -> rd_valid 2 cycles after drain; lane0 out 1,2,3; rd_last only on 3; count 3->0; wrapped=0.
// 2. Write 6 vectors (lane0=1..6), then drain
//    -> count=4, wrapped=1 before drain; out 3,4,5,6; wrapped=0 after last handshake.
// 3. During SEND, hold rd_ready=0 for 5 cycles
//    -> rd_valid, vector_out, rd_last stable; count unchanged until rd_ready=1.
// 4. drain with tracing=1, and drain with count=0
//    -> busy stays 0; no rd_valid; state unchanged.
// 5. Mid-readout, tracing=1 & valid_in=1 with lane0=9
//    -> 9 never read out; remaining order intact. After IDLE, new write lands at wr_ptr.
// 6. Assert reset during SEND of entry 2 of 4
//    -> same cycle: rd_valid=0, count=0, busy=0, wrapped=0; next drain ignored (count=0).

Source files
------------

// File: rtl/trace_buffer_if.sv
// -----------------------------------------------------------------------------
// trace_buffer_if
// Purpose : bundles the capture side (packer -> trace buffer) and the readout
//           side (trace buffer -> host readout) of the trace buffer.
// Ports   : none (signal container only)
//   master : drives tracing, valid_in, vector_in, drain, rd_ready;
//            observes rd_valid, vector_out, rd_last, count, wrapped, busy
//   slave  : the trace buffer itself (directions mirrored)
// -----------------------------------------------------------------------------
interface trace_buffer_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 64
) ();
    localparam int VW = N * DATA_WIDTH;
    localparam int CW = $clog2(TB_SIZE + 1);

    logic          tracing;
    logic          valid_in;
    logic [VW-1:0] vector_in;
    logic          drain;
    logic          rd_ready;
    logic          rd_valid;
    logic [VW-1:0] vector_out;
    logic          rd_last;
    logic [CW-1:0] count;
    logic          wrapped;
    logic          busy;

    modport master (
        output tracing, valid_in, vector_in, drain, rd_ready,
        input  rd_valid, vector_out, rd_last, count, wrapped, busy
    );

    modport slave (
        input  tracing, valid_in, vector_in, drain, rd_ready,
        output rd_valid, vector_out, rd_last, count, wrapped, busy
    );
endinterface

// File: rtl/trace_buffer.sv
// -----------------------------------------------------------------------------
// trace_buffer
// Purpose : circular trace store. While tracing, packed vectors are captured;
//           once full the oldest entry is overwritten so the most recent
//           TB_SIZE vectors are kept. A drain request (with tracing off) reads
//           the stored vectors out oldest-first over a valid/ready port.
// Ports   :
//   i_clk    in  rising-edge clock
//   i_rst    in  asynchronous, active-high reset
//   io_bus   slave modport of trace_buffer_if:
//     tracing, valid_in, vector_in  capture side
//     drain                         one-cycle readout request
//     rd_ready / rd_valid           readout handshake
//     vector_out, rd_last           entry being read, newest-entry flag
//     count, wrapped, busy          occupancy, sticky overwrite flag, readout active
// -----------------------------------------------------------------------------
module trace_buffer #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TB_SIZE    = 64
) (
    input logic           i_clk,
    input logic           i_rst,
    trace_buffer_if.slave io_bus
);
    localparam int VW = N * DATA_WIDTH;
    localparam int PW = $clog2(TB_SIZE);
    localparam int CW = $clog2(TB_SIZE + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    localparam logic [CW-1:0] C_FULL  = CW'(TB_SIZE);
    localparam logic [CW-1:0] C_ONE   = CW'(1);
    localparam logic [CW-1:0] C_ZERO  = CW'(0);
    localparam logic [PW-1:0] C_P_ONE = PW'(1);

    logic [1:0]    r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_wrapped;
    logic          r_rd_valid;
    logic          r_rd_last;
    logic          r_busy;
    logic [VW-1:0] r_vector_out;
    logic [VW-1:0] r_mem [TB_SIZE];

    logic          w_wr_en;
    logic          w_drain_ok;
    logic          w_handshake;

    // Capture only happens while idle; anything arriving during readout is dropped.
    assign w_wr_en     = (r_state == S_IDLE) && io_bus.valid_in && io_bus.tracing;
    // A drain is honoured only with tracing off and something to read.
    assign w_drain_ok  = io_bus.drain && !io_bus.tracing && (r_count != C_ZERO);
    assign w_handshake = r_rd_valid && io_bus.rd_ready;

    // Storage array: write port only, deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= io_bus.vector_in;
        end
    end

    // Control FSM, pointers, occupancy and registered readout outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= {PW{1'b0}};
            r_rd_ptr     <= {PW{1'b0}};
            r_count      <= C_ZERO;
            r_wrapped    <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_busy       <= 1'b0;
            r_vector_out <= {VW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_en) begin
                        r_wr_ptr <= r_wr_ptr + C_P_ONE;
                        if (r_count == C_FULL) begin
                            // Full: the write slot was the oldest entry, so
                            // the read pointer steps past it.
                            r_rd_ptr  <= r_rd_ptr + C_P_ONE;
                            r_wrapped <= 1'b1;
                        end else begin
                            r_count <= r_count + C_ONE;
                        end
                    end else if (w_drain_ok) begin
                        r_state <= S_FETCH;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FETCH: begin
                    r_vector_out <= r_mem[r_rd_ptr];
                    r_rd_last    <= (r_count == C_ONE);
                    r_rd_valid   <= 1'b1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (w_handshake) begin
                        r_rd_ptr   <= r_rd_ptr + C_P_ONE;
                        r_count    <= r_count - C_ONE;
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        if (r_count == C_ONE) begin
                            // Buffer now empty: realign write pointer with
                            // the read pointer so capture restarts cleanly.
                            r_state   <= S_IDLE;
                            r_busy    <= 1'b0;
                            r_wrapped <= 1'b0;
                            r_wr_ptr  <= r_rd_ptr + C_P_ONE;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end else begin
                        r_state <= S_SEND;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.rd_valid   = r_rd_valid;
    assign io_bus.vector_out = r_vector_out;
    assign io_bus.rd_last    = r_rd_last;
    assign io_bus.count      = r_count;
    assign io_bus.wrapped    = r_wrapped;
    assign io_bus.busy       = r_busy;

endmodule

// File: tb/tb_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_trace_buffer
// Purpose : directed self-checking bench for trace_buffer with TB_SIZE=4,
//           N=8, DATA_WIDTH=32. Inputs change 1 time unit after a rising
//           edge; outputs are sampled at the same point.
// Ports   : none
// -----------------------------------------------------------------------------
module tb_trace_buffer;
    localparam int N          = 8;
    localparam int DATA_WIDTH = 32;
    localparam int TB_SIZE    = 4;
    localparam int VW         = N * DATA_WIDTH;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    trace_buffer_if #(.N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TB_SIZE)) bus ();

    trace_buffer #(.N(N), .DATA_WIDTH(DATA_WIDTH), .TB_SIZE(TB_SIZE)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane k of a test vector is {k, 8'h00, v}; lane 0 therefore equals v.
    function automatic logic [VW-1:0] mkvec(input logic [15:0] v);
        logic [VW-1:0] r;
        r = {VW{1'b0}};
        for (int k = 0; k < N; k++) begin
            r[k*32 +: 32] = {8'(k), 8'h00, v};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [15:0] v);
        bus.tracing   = 1'b1;
        bus.valid_in  = 1'b1;
        bus.vector_in = mkvec(v);
        step();
        bus.valid_in  = 1'b0;
        bus.tracing   = 1'b0;
    endtask

    task automatic start_drain();
        bus.drain = 1'b1;
        step();
        bus.drain = 1'b0;
        chk("fetch_busy", VW'(bus.busy), VW'(1));
        chk("fetch_valid", VW'(bus.rd_valid), VW'(0));
    endtask

    // Entered in FETCH with rd_ready=1: one cycle to SEND, one for the handshake.
    task automatic expect_send(input logic [15:0] v, input logic last, input int cnt);
        step();
        chk($sformatf("send_valid_%0d", v), VW'(bus.rd_valid), VW'(1));
        chk($sformatf("send_data_%0d", v), bus.vector_out, mkvec(v));
        chk($sformatf("send_last_%0d", v), VW'(bus.rd_last), VW'(last));
        chk($sformatf("send_count_%0d", v), VW'(bus.count), VW'(cnt));
        step();
        chk($sformatf("ack_valid_%0d", v), VW'(bus.rd_valid), VW'(0));
        chk($sformatf("ack_count_%0d", v), VW'(bus.count), VW'(cnt - 1));
        chk($sformatf("ack_busy_%0d", v), VW'(bus.busy), VW'(last ? 0 : 1));
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.tracing   = 1'b0;
        bus.valid_in  = 1'b0;
        bus.vector_in = {VW{1'b0}};
        bus.drain     = 1'b0;
        bus.rd_ready  = 1'b1;

        // Reset state.
        step();
        step();
        chk("rst_valid", VW'(bus.rd_valid), VW'(0));
        chk("rst_last", VW'(bus.rd_last), VW'(0));
        chk("rst_count", VW'(bus.count), VW'(0));
        chk("rst_wrapped", VW'(bus.wrapped), VW'(0));
        chk("rst_busy", VW'(bus.busy), VW'(0));
        chk("rst_vec", bus.vector_out, {VW{1'b0}});
        rst = 1'b0;
        step();

        // 1: three writes, drain, read 1,2,3 with last only on 3.
        wr(16'd1); wr(16'd2); wr(16'd3);
        chk("t1_count", VW'(bus.count), VW'(3));
        chk("t1_wrapped", VW'(bus.wrapped), VW'(0));
        start_drain();
        expect_send(16'd1, 1'b0, 3);
        expect_send(16'd2, 1'b0, 2);
        expect_send(16'd3, 1'b1, 1);
        chk("t1_wrapped_end", VW'(bus.wrapped), VW'(0));

        // 2: six writes into four slots keep 3..6.
        for (int i = 1; i <= 6; i++) wr(16'(i));
        chk("t2_count", VW'(bus.count), VW'(4));
        chk("t2_wrapped", VW'(bus.wrapped), VW'(1));
        start_drain();
        chk("t2_wrapped_busy", VW'(bus.wrapped), VW'(1));
        expect_send(16'd3, 1'b0, 4);
        expect_send(16'd4, 1'b0, 3);
        expect_send(16'd5, 1'b0, 2);
        expect_send(16'd6, 1'b1, 1);
        chk("t2_wrapped_end", VW'(bus.wrapped), VW'(0));

        // 3: back-pressure holds the entry stable.
        wr(16'd7); wr(16'd8);
        bus.rd_ready = 1'b0;
        start_drain();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_hold_valid", VW'(bus.rd_valid), VW'(1));
            chk("t3_hold_data", bus.vector_out, mkvec(16'd7));
            chk("t3_hold_last", VW'(bus.rd_last), VW'(0));
            chk("t3_hold_count", VW'(bus.count), VW'(2));
        end
        bus.rd_ready = 1'b1;
        step();
        chk("t3_ack_valid", VW'(bus.rd_valid), VW'(0));
        chk("t3_ack_count", VW'(bus.count), VW'(1));
        expect_send(16'd8, 1'b1, 1);

        // 4: drain on empty buffer, drain while tracing, drain with a write.
        bus.drain = 1'b1;
        step();
        bus.drain = 1'b0;
        chk("t4_empty_busy", VW'(bus.busy), VW'(0));
        step();
        chk("t4_empty_valid", VW'(bus.rd_valid), VW'(0));
        wr(16'd10);
        bus.tracing = 1'b1;
        bus.drain   = 1'b1;
        step();
        bus.drain   = 1'b0;
        bus.tracing = 1'b0;
        chk("t4_trace_busy", VW'(bus.busy), VW'(0));
        chk("t4_trace_count", VW'(bus.count), VW'(1));
        step();
        chk("t4_trace_valid", VW'(bus.rd_valid), VW'(0));
        bus.drain = 1'b1;
        wr(16'd11);
        bus.drain = 1'b0;
        chk("t4_wrdrain_busy", VW'(bus.busy), VW'(0));
        chk("t4_wrdrain_count", VW'(bus.count), VW'(2));
        wr(16'd12); wr(16'd13);

        // 5: writes during readout are dropped; order intact.
        start_drain();
        expect_send(16'd10, 1'b0, 4);
        bus.tracing   = 1'b1;
        bus.valid_in  = 1'b1;
        bus.vector_in = mkvec(16'd9);
        expect_send(16'd11, 1'b0, 3);
        bus.tracing   = 1'b0;
        bus.valid_in  = 1'b0;
        expect_send(16'd12, 1'b0, 2);
        expect_send(16'd13, 1'b1, 1);
        wr(16'd14);
        chk("t5_count", VW'(bus.count), VW'(1));
        start_drain();
        expect_send(16'd14, 1'b1, 1);

        // 6: reset in the middle of SEND of entry 2 of 4 (wrapped set).
        for (int i = 20; i <= 24; i++) wr(16'(i));
        chk("t6_wrapped", VW'(bus.wrapped), VW'(1));
        start_drain();
        expect_send(16'd21, 1'b0, 4);
        step();
        chk("t6_send2_valid", VW'(bus.rd_valid), VW'(1));
        chk("t6_send2_data", bus.vector_out, mkvec(16'd22));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", VW'(bus.rd_valid), VW'(0));
        chk("t6_rst_count", VW'(bus.count), VW'(0));
        chk("t6_rst_busy", VW'(bus.busy), VW'(0));
        chk("t6_rst_wrapped", VW'(bus.wrapped), VW'(0));
        step();
        rst = 1'b0;
        bus.drain = 1'b1;
        step();
        bus.drain = 1'b0;
        chk("t6_drain_busy", VW'(bus.busy), VW'(0));
        step();
        chk("t6_drain_valid", VW'(bus.rd_valid), VW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
